// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshakes.
// Shift-add multiply and restoring divide on magnitudes, signs fixed when the result is loaded.
module rv_muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                is_div, sa, sb, bz_in, ovf_in, special_in;
  logic [XLEN-1:0]     abs_a, abs_b, special_res;
  logic [XLEN:0]       mul_sum, div_sh;
  logic [XLEN+1:0]     div_diff;
  logic                borrow;
  logic [2*XLEN-1:0]   mul_next, div_next, iter, prod;
  logic [XLEN-1:0]     quo, rem, fin;

  assign is_div      = funct3[2];
  assign sa          = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
  assign sb          = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
  assign abs_a       = (sa && rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs_b       = (sb && rs2[XLEN-1]) ? -rs2 : rs2;
  assign bz_in       = (rs2 == '0);
  assign ovf_in      = !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special_in  = FAST_SPECIAL && is_div && (bz_in || ovf_in);
  assign special_res = funct3[1] ? (bz_in ? rs1 : '0) : (bz_in ? '1 : rs1);

  // One multiplier bit per step: add into the high half, then shift the whole product right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One quotient bit per step: {remainder, quotient} shifts left, trial-subtract the divisor.
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = {1'b0, div_sh} - {2'b0, opb_q};
  assign borrow   = div_diff[XLEN+1];
  assign div_next = {borrow ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], ~borrow};
  assign iter     = op_q[2] ? div_next : mul_next;

  // A zero divisor never borrows, giving an all-ones quotient that must not be sign-flipped.
  assign prod = (neg_a_q ^ neg_b_q) ? -iter : iter;
  assign quo  = iter[XLEN-1:0];
  assign rem  = iter[2*XLEN-1:XLEN];
  assign fin  = op_q[2] ? (op_q[1] ? (neg_a_q ? -rem : rem)
                                   : ((opb_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -quo : quo)))
                        : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_d    = funct3;
          neg_a_d = sa && rs1[XLEN-1];
          neg_b_d = sb && rs2[XLEN-1];
          opb_d   = is_div ? abs_b : abs_a;
          acc_d   = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          cnt_d   = CW'(XLEN);
          state_d = special_in ? DONE : CALC;
          if (special_in) result_d = special_res;
        end
        CALC: begin
          acc_d = iter;
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d  = DONE;
            result_d = fin;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed checks of the RV32M multiply/divide unit (XLEN=32, FAST_SPECIAL=1).
module tb_rv_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  int          tests = 0;
  int          fails = 0;
  int          lat;
  int          seen;

  rv_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    start(f, a, b);
    wait_valid(n);
    chk({tag, "_lat"}, n, exp_lat);
    chk(tag, result, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
    chk("reset_result", result, 32'd0);
    reset_n = 1'b1;

    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mul_by_zero", 3'b000, 32'h12345678, 32'd0, 32'd0, 33);
    run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_20_m3", 3'b100, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run_op("rem_20_m3", 3'b110, 32'd20, 32'hFFFFFFFD, 32'd2, 33);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    start(3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    chk("hold_lat", lat, 33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
      chk("hold_result", result, 32'd14);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("release_flags", {30'd0, out_valid, in_ready}, 32'd1);
    run_op("mul_after_hold", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    start(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_result_held", result, 32'd12);

    start(3'b000, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("areset_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
    chk("areset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
    run_op("mulhu_after_reset", 3'b011, 32'h00010000, 32'h00030000, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
